// File: rtl/tdm_demux3_pkg.sv
// Shared types, slot constants and helpers for the 3-channel TDM demultiplexer.
// Defining TDM_DEMUX3_PARITY_EN adds a trailing even-parity bit to every channel word.
package tdm_demux3_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] SLOT_CH0 = 2'b00;
    localparam logic [1:0] SLOT_CH1 = 2'b01;
    localparam logic [1:0] SLOT_CH2 = 2'b10;

`ifdef TDM_DEMUX3_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    // Next slot in the 0,1,2 rotation; 3 is never produced.
    function automatic logic [1:0] slot_inc(input logic [1:0] s);
        return (s == SLOT_CH2) ? SLOT_CH0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/tdm_demux3_lane.sv
// One demultiplexer lane: deserializer, bit counter, holding register with
// valid/ready, sticky overflow and (with TDM_DEMUX3_PARITY_EN) a parity check.
module tdm_demux3_lane
    import tdm_demux3_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             restart,
    input  logic             din,
    input  logic             rdy,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] dout,
    output logic             vld,
    output logic             ovf
`ifdef TDM_DEMUX3_PARITY_EN
    ,
    output logic             perr
`endif
);

    localparam int unsigned NBITS = WIDTH + PAR_BITS;
    localparam int unsigned CW    = $clog2(NBITS + 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_base;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_base;
    logic             data_bit;
    logic             complete;
    logic             ovf_set;

    // A restart makes the current bit (if any) the first bit of a fresh word.
    always_comb begin
        cnt_base = restart ? '0 : cnt;
        sr_base  = restart ? '0 : sr;
        if (MSB_FIRST != 0) begin
            sr_next = {sr_base[WIDTH-2:0], din};
        end else begin
            sr_next = {din, sr_base[WIDTH-1:1]};
        end
        data_bit = (cnt_base < CW'(WIDTH));
        complete = bit_en && (cnt_base == CW'(NBITS - 1));
        ovf_set  = complete && vld && !rdy;
`ifdef TDM_DEMUX3_PARITY_EN
        word = sr_base;
`else
        word = sr_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (bit_en) begin
            sr  <= data_bit ? sr_next : sr_base;
            cnt <= complete ? '0 : cnt_base + CW'(1);
        end else if (restart) begin
            sr  <= '0;
            cnt <= '0;
        end
    end

`ifdef TDM_DEMUX3_PARITY_EN
    logic par;
    logic par_base;

    assign par_base = restart ? 1'b0 : par;

    // Running XOR of all word bits; odd total at the parity bit means error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par  <= 1'b0;
            perr <= 1'b0;
        end else begin
            if (bit_en) begin
                par <= complete ? 1'b0 : (par_base ^ din);
            end else if (restart) begin
                par <= 1'b0;
            end
            if (complete && !ovf_set) begin
                perr <= par_base ^ din;
            end
        end
    end
`endif

    // Holding register: a completed word is dropped only if the old one is not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            vld  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            ovf <= (ovf & ~ovf_clr) | ovf_set;
            if (complete && !ovf_set) begin
                dout <= word;
                vld  <= 1'b1;
            end else if (vld && rdy) begin
                vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tdm_demux3.sv
// 1:3 bit-interleaved TDM demultiplexer: frame-alignment FSM and slot counter
// steering bits into three deserializing lanes. TDM_DEMUX3_PARITY_EN adds perr.
module tdm_demux3
    import tdm_demux3_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [1:0]       slot,
    output logic             locked,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic             vld0,
    output logic             vld1,
    output logic             vld2,
    input  logic             rdy0,
    input  logic             rdy1,
    input  logic             rdy2,
    output logic [2:0]       ovf,
    input  logic             ovf_clr
`ifdef TDM_DEMUX3_PARITY_EN
    ,
    output logic [2:0]       perr
`endif
);

    state_t     state;
    logic       sync;
    logic [2:0] lane_en;

    assign sync = din_valid & frame_sync;

    // A qualified sync always lands in channel 0 regardless of the current slot.
    always_comb begin
        lane_en = 3'b000;
        if (sync) begin
            lane_en = 3'b001;
        end else if (din_valid && state == RUN) begin
            case (slot)
                SLOT_CH0: lane_en = 3'b001;
                SLOT_CH1: lane_en = 3'b010;
                SLOT_CH2: lane_en = 3'b100;
                default:  lane_en = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HUNT;
            slot   <= SLOT_CH0;
            locked <= 1'b0;
        end else if (sync) begin
            state  <= RUN;
            slot   <= SLOT_CH1;
            locked <= 1'b1;
        end else if (din_valid && state == RUN) begin
            slot <= slot_inc(slot);
        end
    end

    tdm_demux3_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_en  (lane_en[0]),
        .restart (sync),
        .din     (din),
        .rdy     (rdy0),
        .ovf_clr (ovf_clr),
        .dout    (dout0),
        .vld     (vld0),
        .ovf     (ovf[0])
`ifdef TDM_DEMUX3_PARITY_EN
        ,
        .perr    (perr[0])
`endif
    );

    tdm_demux3_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_en  (lane_en[1]),
        .restart (sync),
        .din     (din),
        .rdy     (rdy1),
        .ovf_clr (ovf_clr),
        .dout    (dout1),
        .vld     (vld1),
        .ovf     (ovf[1])
`ifdef TDM_DEMUX3_PARITY_EN
        ,
        .perr    (perr[1])
`endif
    );

    tdm_demux3_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_en  (lane_en[2]),
        .restart (sync),
        .din     (din),
        .rdy     (rdy2),
        .ovf_clr (ovf_clr),
        .dout    (dout2),
        .vld     (vld2),
        .ovf     (ovf[2])
`ifdef TDM_DEMUX3_PARITY_EN
        ,
        .perr    (perr[2])
`endif
    );

endmodule
